multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Opcode-driven control FSM for the multicycle MIPS datapath. It is the stateful successor to the single-cycle main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and stalls on a memory ready handshake. It adds halt and illegal-opcode handling, and is parametrised in opcode width and memory wait tolerance.

Parameters:
OPCODE_W, 6, width of the opcode field instruction[31:26].
STATE_W, 4, width of the state register exported on state.
WAIT_MAX, 255, memory-wait cycles tolerated before mem_timeout is set; 0 disables the timeout.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
opcode  input  OPCODE_W  opcode from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
pcWrite  output  1  unconditional PC load
pcWriteCond  output  1  PC load if branch condition is true
branchNe  output  1  branch condition is !zero instead of zero
iorD  output  1  memory address select: 0=PC, 1=ALUOut
memRead  output  1  memory read strobe
memWrite  output  1  memory write strobe
irWrite  output  1  instruction register load
memToReg  output  1  writeback select: 1=MDR
regDst  output  1  destination select: 1=rd, 0=rt
regWrite  output  1  register file write
aluSrcA  output  1  ALU A select: 0=PC, 1=regA
aluSrcB  output  2  ALU B select: 00=regB, 01=4, 10=sext imm, 11=sext imm<<2
aluOp  output  2  ALU op: 00=add, 01=sub, 10=funct, 11=add (immediate)
pcSource  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
halted  output  1  halt instruction retired (sticky)
illegal  output  1  unknown opcode decoded (sticky)
mem_timeout  output  1  wait limit exceeded (sticky)
state  output  STATE_W  current state, for debug

Behaviour:
- Reset: rst high forces state to FETCH (0). halted, illegal, mem_timeout and the wait counter clear to 0.
- Outputs are Moore-decoded from state, except pcWrite and irWrite in FETCH, which are qualified by mem_ready.
- While rst is high, outputs equal FETCH decode: memRead=1, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00, iorD=0, pcWrite=irWrite=mem_ready. All other outputs are 0.
- States and the signals each asserts (all unlisted outputs are 0):
  - FETCH(0): as listed under reset. Holds until mem_ready=1, then goes to DECODE.
  - DECODE(1): aluSrcA=0, aluSrcB=11, aluOp=00. Dispatch on opcode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - 111111 -> HALT
    - anything else -> FETCH, and set illegal.
  - MEMADR(2): aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): memRead=1, iorD=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB(4): regWrite=1, memToReg=1, regDst=0. Goes to FETCH.
  - MEMWR(5): memWrite=1, iorD=1. Holds until mem_ready=1, then goes to FETCH.
  - EXEC(6): aluSrcA=1, aluSrcB=00, aluOp=10. Goes to ALUWB.
  - ALUWB(7): regWrite=1, regDst=1, memToReg=0. Goes to FETCH.
  - BRANCH(8): aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. Goes to FETCH.
  - ADDIEX(9): aluSrcA=1, aluSrcB=10, aluOp=11. Goes to ADDIWB.
  - ADDIWB(10): regWrite=1, regDst=0, memToReg=0. Goes to FETCH.
  - JUMP(11): pcWrite=1, pcSource=10. Goes to FETCH.
  - HALT(12): all strobes 0 and halted=1. Terminal; only rst exits it.
- Cycle counts with mem_ready tied to 1:
  - R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Wait counter:
  - Increments each cycle in a memory state with mem_ready=0.
  - Clears when mem_ready=1 or on any state change.
  - When the count reaches WAIT_MAX (WAIT_MAX>0), mem_timeout is set and the state still holds.
- Memory strobes stay asserted for the whole of a stall.
- Async reset mid-instruction: the instruction is aborted with no further strobes, and the next cycle after release is FETCH.
- opcode is sampled only in DECODE and MEMADR; the IR holds it stable.

Optional Feature:
BNE_SUPPORT_EN. When defined, DECODE maps 000101 to BRANCH and branchNe is asserted in BRANCH for that opcode. The opcode is latched in DECODE via a 1-bit register. When undefined, 000101 is illegal and branchNe is tied to 0.

Test Plan:
- Reset, then mem_ready=1, opcode=000000 -> states 0,1,6,7,0. regWrite=1 and regDst=1 only in state 7.
- opcode=100011, mem_ready low 3 cycles in MEMRD -> 3 stalled cycles at state 3 with memRead=1 and iorD=1, then MEMWB with memToReg=1. lw takes 8 cycles.
- opcode=101011 then opcode=000100 -> memWrite pulses one cycle in state 5. The beq pass asserts pcWriteCond=1, aluOp=01, pcSource=01 for one cycle.
- opcode=000010 then 111111 -> pcWrite=1, pcSource=10 in JUMP. Then halted=1 and all strobes stay 0 for 20 cycles until rst.
- opcode=010101 -> illegal=1 after DECODE and FETCH resumes. With BNE_SUPPORT_EN defined, 000101 gives branchNe=1 in BRANCH.
- WAIT_MAX=4, mem_ready held low in FETCH -> mem_timeout=1 on the 4th stall cycle. Asserting rst mid-MEMRD gives state=0 in the same cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: opcode-driven control FSM for the multicycle MIPS datapath.
// The FSM sequences each instruction through fetch, decode, execute, memory and writeback.
// It stalls on mem_ready and flags halt, illegal opcode and memory-wait timeout.
// Optional feature macro: BNE_SUPPORT_EN (decodes bne 000101 and drives branchNe).
//
// state  | meaning
// -------+---------------------------------------------
// 0      | FETCH   read instruction, PC+4 (waits on mem)
// 1      | DECODE  register read, branch target, dispatch
// 2      | MEMADR  lw/sw address compute
// 3      | MEMRD   lw data read (waits on mem)
// 4      | MEMWB   lw writeback from MDR
// 5      | MEMWR   sw data write (waits on mem)
// 6      | EXEC    R-type ALU operation
// 7      | ALUWB   R-type writeback to rd
// 8      | BRANCH  compare and conditional PC load
// 9      | ADDIEX  addi ALU operation
// 10     | ADDIWB  addi writeback to rt
// 11     | JUMP    PC load from jump target
// 12     | HALT    terminal, only reset leaves it
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4,
    parameter int WAIT_MAX = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic                branchNe,
    output logic                iorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                irWrite,
    output logic                memToReg,
    output logic                regDst,
    output logic                regWrite,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [1:0]          aluOp,
    output logic [1:0]          pcSource,
    output logic                halted,
    output logic                illegal,
    output logic                mem_timeout,
    output logic [STATE_W-1:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(6'b111111);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);

    localparam int                 CNT_W    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    state_t            state_q, nxt;
    ctrl_t             ctrl_q;
    logic              bad_op;
    logic              stall;
    logic [CNT_W-1:0]  wait_cnt;
    logic              halted_q, illegal_q, timeout_q;

    // zero is consumed by the datapath's branch gate, not by the sequencer.
    logic unused_zero;
    assign unused_zero = zero;

    // Moore control word for each state; FETCH pc/ir loads are added separately.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:  begin c.mem_write = 1'b1; c.ior_d = 1'b1; end
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
            end
            S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection including opcode dispatch out of DECODE.
    always_comb begin
        nxt    = state_q;
        bad_op = 1'b0;
        case (state_q)
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_BEQ:       nxt = S_BRANCH;
`ifdef BNE_SUPPORT_EN
                    OP_BNE:       nxt = S_BRANCH;
`endif
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    OP_HALT:      nxt = S_HALT;
                    default: begin
                        nxt    = S_FETCH;
                        bad_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_ALUWB;
            S_BRANCH: nxt = S_FETCH;
            S_ADDIEX: nxt = S_ADDIWB;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_FETCH;
        endcase
    end

    // A stall is any memory-state cycle without the ready handshake; the state holds then.
    assign stall = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                   && !mem_ready;

    // State register, registered control word and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ctrl_q    <= decode(S_FETCH);
            wait_cnt  <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= nxt;
            ctrl_q    <= decode(nxt);
            halted_q  <= halted_q | (nxt == S_HALT);
            illegal_q <= illegal_q | ((state_q == S_DECODE) && bad_op);
            if (!stall) begin
                wait_cnt <= '0;
            end else if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if ((WAIT_MAX > 0) && stall && (wait_cnt == CNT_LAST)) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef BNE_SUPPORT_EN
    logic bne_q;

    // One-bit opcode latch: remembers in DECODE whether the branch is a bne.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bne_q <= 1'b0;
        end else begin
            bne_q <= (state_q == S_DECODE) && (nxt == S_BRANCH) && (opcode == OP_BNE);
        end
    end

    assign branchNe = bne_q;
`else
    assign branchNe = 1'b0;
`endif

    assign pcWrite     = ctrl_q.pc_write | ((state_q == S_FETCH) & mem_ready);
    assign irWrite     = (state_q == S_FETCH) & mem_ready;
    assign pcWriteCond = ctrl_q.pc_write_cond;
    assign iorD        = ctrl_q.ior_d;
    assign memRead     = ctrl_q.mem_read;
    assign memWrite    = ctrl_q.mem_write;
    assign memToReg    = ctrl_q.mem_to_reg;
    assign regDst      = ctrl_q.reg_dst;
    assign regWrite    = ctrl_q.reg_write;
    assign aluSrcA     = ctrl_q.alu_src_a;
    assign aluSrcB     = ctrl_q.alu_src_b;
    assign aluOp       = ctrl_q.alu_op;
    assign pcSource    = ctrl_q.pc_source;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;
    assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with WAIT_MAX=4.
// Every cycle it checks the state and the full control word against a hand-written state table.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic       halted, illegal, mem_timeout;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;

    multicycle_control #(.OPCODE_W(6), .STATE_W(4), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .branchNe(branchNe),
        .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
        .halted(halted), .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    logic [16:0] ctl;
    assign ctl = {pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite,
                  memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hand-written control table: {pcW,pcWC,bne,iorD,mRd,mWr,irW,m2r,rDst,rW,aA,aB,aOp,pSrc}.
    function automatic logic [16:0] spec_ctl(input int s, input logic mr, input logic bne);
        case (s)
            0:  return {mr,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mr,   1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
            1:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
            2:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            3:  return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
            4:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            5:  return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
            6:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            7:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            8:  return {1'b0, 1'b1, bne,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            9:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11, 2'b00};
            10: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            11: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
            default: return 17'd0;
        endcase
    endfunction

    // Advance one clock and check state plus the whole control word.
    task automatic step(input string tag, input int exp_s, input logic bne = 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "/state"}, 32'(state), 32'(exp_s));
        chk({tag, "/ctl"}, 32'(ctl), 32'(spec_ctl(exp_s, mem_ready, bne)));
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        chk("rst/state", 32'(state), 32'd0);
        chk("rst/ctl", 32'(ctl), 32'(spec_ctl(0, 1'b1, 1'b0)));
        chk("rst/flags", {29'd0, halted, illegal, mem_timeout}, 32'd0);
        mem_ready = 1'b0;
        #1;
        chk("rst/ctl_nordy", 32'(ctl), 32'(spec_ctl(0, 1'b0, 1'b0)));
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // R-type: 0,1,6,7,0
        opcode = 6'b000000;
        step("rtype", 1); step("rtype", 6); step("rtype", 7); step("rtype", 0);

        // lw with three stall cycles in MEMRD: 8 cycles total
        opcode = 6'b100011;
        step("lw", 1); step("lw", 2);
        mem_ready = 1'b0;
        step("lw", 3); step("lw_stall", 3); step("lw_stall", 3); step("lw_stall", 3);
        mem_ready = 1'b1;
        step("lw", 4); step("lw", 0);
        chk("lw/no_timeout", 32'(mem_timeout), 32'd0);

        // sw then beq
        opcode = 6'b101011;
        step("sw", 1); step("sw", 2); step("sw", 5); step("sw", 0);
        zero   = 1'b1;
        opcode = 6'b000100;
        step("beq", 1); step("beq", 8); step("beq", 0);

        // illegal opcode returns to FETCH and sets the sticky flag
        chk("illegal/before", 32'(illegal), 32'd0);
        opcode = 6'b010101;
        step("illegal", 1); step("illegal", 0);
        chk("illegal/after", 32'(illegal), 32'd1);

`ifdef BNE_SUPPORT_EN
        opcode = 6'b000101;
        step("bne", 1); step("bne", 8, 1'b1); step("bne", 0);
`else
        opcode = 6'b000101;
        step("bne_illegal", 1); step("bne_illegal", 0);
`endif
        chk("illegal/sticky", 32'(illegal), 32'd1);

        // jump then halt
        opcode = 6'b000010;
        step("j", 1); step("j", 11); step("j", 0);
        opcode = 6'b111111;
        step("halt", 1);
        chk("halt/before", 32'(halted), 32'd0);
        step("halt", 12);
        chk("halt/set", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            step("halt_hold", 12);
        end
        chk("halt/sticky", 32'(halted), 32'd1);

        // async reset out of HALT, seen within the same cycle
        mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst/state", 32'(state), 32'd0);
        chk("arst/flags", {29'd0, halted, illegal, mem_timeout}, 32'd0);
        chk("arst/ctl", 32'(ctl), 32'(spec_ctl(0, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // FETCH stall: timeout on the 4th stall cycle, state keeps holding
        for (int i = 1; i <= 3; i++) begin
            step("tmo_stall", 0);
            chk("tmo/early", 32'(mem_timeout), 32'd0);
        end
        step("tmo_stall", 0);
        chk("tmo/set", 32'(mem_timeout), 32'd1);
        step("tmo_hold", 0);
        mem_ready = 1'b1;
        opcode    = 6'b100011;
        step("tmo_exit", 1);
        chk("tmo/sticky", 32'(mem_timeout), 32'd1);

        // async reset in the middle of a stalled MEMRD
        step("mid_lw", 2);
        mem_ready = 1'b0;
        step("mid_lw", 3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst/state", 32'(state), 32'd0);
        chk("mid_rst/ctl", 32'(ctl), 32'(spec_ctl(0, 1'b0, 1'b0)));
        chk("mid_rst/tmo_clr", 32'(mem_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        chk("mid_rst/release", 32'(state), 32'd0);
        step("after_rst", 1); step("after_rst", 2); step("after_rst", 3);
        step("after_rst", 4); step("after_rst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
